// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame sequencer for the pixel pipeline
// Gates pixel issue, drains the pipeline for config latches, and tracks frame and error status.
module frame_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int MAX_PZ          = 8,
  parameter int PZ_FIELD_WIDTH  = 4,
  parameter int PIPE_DEPTH      = 32,
  parameter int SETTLE_CYCLES   = 2,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       run_en,
  input  logic                       commit,
  input  logic [DATA_WIDTH-1:0]      cfg_word,
  input  logic                       gen_valid,
  input  logic                       gen_done,
  output logic                       gen_ready,
  input  logic                       pix_valid,
  input  logic                       pix_ready,
  output logic                       latch,
  output logic [PZ_FIELD_WIDTH-1:0]  num_zeros,
  output logic [PZ_FIELD_WIDTH-1:0]  num_poles,
  output logic                       busy,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       cfg_error,
  output logic                       proto_error,
  input  logic                       err_clear
);
  localparam int HALF  = DATA_WIDTH / 2;
  localparam int INF_W = $clog2(PIPE_DEPTH + 1);
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [INF_W-1:0]          INF_MAX     = INF_W'(PIPE_DEPTH);
  localparam logic [SET_W-1:0]          SETTLE_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [PZ_FIELD_WIDTH-1:0] PZ_MAX      = PZ_FIELD_WIDTH'(MAX_PZ);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_SETTLE, S_RUN, S_DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [INF_W-1:0]          inflight;
  logic [SET_W-1:0]          settle_cnt;
  logic                      pending;
  logic                      issue, retire, frame_end;
  logic [PZ_FIELD_WIDTH-1:0] zero_field, pole_field;
  logic                      zero_over, pole_over;
  logic                      cfg_err_evt, proto_evt;
  logic                      unused_cfg_bits;

  assign zero_field      = cfg_word[HALF +: PZ_FIELD_WIDTH];
  assign pole_field      = cfg_word[0 +: PZ_FIELD_WIDTH];
  assign zero_over       = zero_field > PZ_MAX;
  assign pole_over       = pole_field > PZ_MAX;
  assign unused_cfg_bits = ^cfg_word;

  assign gen_ready = (state == S_RUN) && (inflight < INF_MAX);
  assign latch     = (state == S_LATCH);
  assign busy      = (state != S_IDLE);

  assign issue     = gen_valid & gen_ready;
  assign retire    = pix_valid & pix_ready;
  assign frame_end = issue & gen_done;
  // A retire with nothing in flight is a protocol violation; a concurrent issue covers it.
  assign proto_evt   = retire & ~issue & (inflight == '0);
  assign cfg_err_evt = (state == S_LATCH) & (zero_over | pole_over);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (run_en) state_nxt = S_LATCH;
      S_LATCH:  state_nxt = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
      S_SETTLE: if (settle_cnt == SETTLE_LAST) state_nxt = S_RUN;
      S_RUN:    if (frame_end && (pending || !run_en)) state_nxt = S_DRAIN;
      S_DRAIN:  if (inflight == '0) state_nxt = run_en ? S_LATCH : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight    <= '0;
      settle_cnt  <= '0;
      pending     <= 1'b0;
      num_zeros   <= '0;
      num_poles   <= '0;
      frame_count <= '0;
      cfg_error   <= 1'b0;
      proto_error <= 1'b0;
    end else begin
      if (issue && !retire)
        inflight <= inflight + 1'b1;
      else if (retire && !issue && (inflight != '0))
        inflight <= inflight - 1'b1;

      // A commit landing in the latch cycle belongs to the following frame.
      pending <= (state == S_LATCH) ? commit : (pending | commit);

      if (state == S_LATCH) begin
        settle_cnt <= '0;
        num_zeros  <= zero_over ? PZ_MAX : zero_field;
        num_poles  <= pole_over ? PZ_MAX : pole_field;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end

      if (frame_end) frame_count <= frame_count + 1'b1;

      cfg_error   <= cfg_err_evt | (cfg_error & ~err_clear);
      proto_error <= proto_evt | (proto_error & ~err_clear);
    end
  end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - scoreboard bench for frame_sequencer
`timescale 1ns/1ps
module tb_frame_sequencer;
  localparam int FRAME_LEN = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        run_en, commit, gen_valid, gen_done, pix_valid, pix_ready, err_clear;
  logic [15:0] cfg_word;
  logic        gen_ready, latch, busy, cfg_error, proto_error;
  logic [3:0]  num_zeros, num_poles;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  frame_sequencer dut (
    .clk(clk), .reset(reset), .run_en(run_en), .commit(commit), .cfg_word(cfg_word),
    .gen_valid(gen_valid), .gen_done(gen_done), .gen_ready(gen_ready),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .latch(latch),
    .num_zeros(num_zeros), .num_poles(num_poles), .busy(busy),
    .frame_count(frame_count), .cfg_error(cfg_error), .proto_error(proto_error),
    .err_clear(err_clear)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int delay = 8;
  int gen_left = 0;
  int frames_to_go = 0;
  bit stall = 0;
  bit spurious = 0;
  int rt_q[$];
  logic [7:0] exp_q[$];
  int m_inf = 0;
  int exp_frames = 0;
  int ready_gaps = 0;
  int latch_seen = 0;
  int last_latch_cyc = 0;
  int zero_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void push_cfg(input logic [15:0] w);
    logic [3:0] z, p;
    z = w[11:8];
    p = w[3:0];
    if (z > 4'd8) z = 4'd8;
    if (p > 4'd8) p = 4'd8;
    exp_q.push_back({z, p});
  endfunction

  task automatic tick();
    bit iss, ret, real_ret, done_iss, was_latch, avail;
    logic [7:0] e;
    avail     = (rt_q.size() > 0) && (rt_q[0] <= cyc);
    gen_valid = (gen_left > 0);
    gen_done  = (gen_left == 1);
    pix_valid = spurious || avail;
    pix_ready = !stall;
    #1;
    iss       = gen_valid & gen_ready;
    ret       = pix_valid & pix_ready;
    real_ret  = ret && avail;
    done_iss  = iss & gen_done;
    was_latch = latch;
    if (was_latch) begin
      latch_seen++;
      last_latch_cyc = cyc;
    end
    if (gen_valid && !gen_ready) ready_gaps++;
    @(posedge clk);
    #1;
    cyc++;
    commit = 1'b0;
    err_clear = 1'b0;
    spurious = 1'b0;
    if (iss) begin
      gen_left--;
      rt_q.push_back(cyc - 1 + delay);
      m_inf++;
    end
    if (real_ret) begin
      void'(rt_q.pop_front());
      m_inf--;
      if (m_inf == 0) zero_cyc = cyc;
    end
    if (done_iss) begin
      exp_frames++;
      chk("frame_count", frame_count, 32'(16'(exp_frames)));
      if (frames_to_go > 0) begin
        frames_to_go--;
        gen_left = FRAME_LEN;
      end
    end
    if (was_latch) begin
      if (exp_q.size() == 0) chk("latch_unexpected", was_latch, 0);
      else begin
        e = exp_q.pop_front();
        chk("num_zeros", num_zeros, e[7:4]);
        chk("num_poles", num_poles, e[3:0]);
      end
    end
  endtask

  task automatic run_until_drained(input string tag, input int bound);
    int n = 0;
    while ((gen_left > 0 || rt_q.size() > 0) && n < bound) begin
      tick();
      n++;
    end
    chk(tag, (n < bound), 1);
  endtask

  task automatic wait_ready(input string tag, input int bound);
    int n = 0;
    while (!gen_ready && n < bound) begin
      tick();
      n++;
    end
    chk(tag, gen_ready, 1);
  endtask

  initial begin
    int n;
    int drain_bad;
    reset = 1'b1; run_en = 1'b0; commit = 1'b0; cfg_word = '0; gen_valid = 1'b0;
    gen_done = 1'b0; pix_valid = 1'b0; pix_ready = 1'b0; err_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gen_ready", gen_ready, 0);
    chk("rst_latch", latch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cfg_error", cfg_error, 0);
    chk("rst_proto_error", proto_error, 0);
    chk("rst_num_zeros", num_zeros, 0);
    chk("rst_num_poles", num_poles, 0);
    chk("rst_frame_count", frame_count, 0);
    reset = 1'b0;

    // startup latency: latch in cycle 1, gen_ready in cycle 4
    cfg_word = 16'h0302; run_en = 1'b1; push_cfg(cfg_word);
    tick(); chk("start_latch", latch, 1);
    chk("start_busy", busy, 1);
    tick(); chk("settle1_gen_ready", gen_ready, 0);
    tick(); chk("settle2_gen_ready", gen_ready, 0);
    tick(); chk("run_gen_ready", gen_ready, 1);

    // two back-to-back frames, no commit
    ready_gaps = 0; latch_seen = 0;
    gen_left = FRAME_LEN; frames_to_go = 1;
    run_until_drained("b2b_timeout", 400);
    chk("b2b_ready_gaps", ready_gaps, 0);
    chk("b2b_latches", latch_seen, 0);
    chk("b2b_frames", frame_count, 2);

    // commit mid-frame, then stall the packer during drain
    gen_left = FRAME_LEN;
    repeat (20) tick();
    cfg_word = 16'h0504; commit = 1'b1; push_cfg(cfg_word);
    n = 0;
    while (gen_left > 0 && n < 200) begin tick(); n++; end
    chk("commit_frame_timeout", (n < 200), 1);
    stall = 1'b1; drain_bad = 0;
    repeat (10) begin
      tick();
      if (gen_ready || latch) drain_bad++;
    end
    chk("drain_hold", drain_bad, 0);
    chk("drain_busy", busy, 1);
    stall = 1'b0; latch_seen = 0; n = 0;
    while (latch_seen == 0 && n < 60) begin tick(); n++; end
    chk("drain_latch_seen", latch_seen, 1);
    chk("drain_latch_delay", last_latch_cyc - zero_cyc, 1);
    wait_ready("post_drain_ready", 20);

    // back-pressure: inflight saturates at the pipe depth
    stall = 1'b1; gen_left = 100;
    repeat (60) tick();
    chk("bp_inflight", m_inf, 32);
    chk("bp_gen_ready", gen_ready, 0);
    stall = 1'b0;
    wait_ready("bp_resume", 5);
    run_until_drained("bp_timeout", 500);

    // errors: clamped zero count, spurious retire, clear priority
    cfg_word = 16'h0C01; commit = 1'b1; push_cfg(cfg_word);
    gen_left = 16;
    run_until_drained("err_frame_timeout", 200);
    repeat (6) tick();
    chk("cfg_error_set", cfg_error, 1);
    spurious = 1'b1;
    tick(); chk("proto_error_set", proto_error, 1);
    spurious = 1'b1; err_clear = 1'b1;
    tick(); chk("proto_wins_clear", proto_error, 1);
    chk("cfg_cleared", cfg_error, 0);
    err_clear = 1'b1;
    tick(); chk("proto_cleared", proto_error, 0);

    // run_en drop mid-frame finishes the frame then idles
    gen_left = 40;
    repeat (10) tick();
    run_en = 1'b0;
    tick(); chk("stop_frame_continues", gen_ready, 1);
    run_until_drained("stop_timeout", 300);
    n = 0;
    while (busy && n < 20) begin tick(); n++; end
    chk("stop_idle_busy", busy, 0);
    chk("stop_gen_ready", gen_ready, 0);
    chk("stop_frames", frame_count, 32'(16'(exp_frames)));

    // commit during the latch cycle stays pending for the next frame
    cfg_word = 16'h0201; run_en = 1'b1; push_cfg(cfg_word); latch_seen = 0;
    tick(); chk("relatch_pulse", latch, 1);
    commit = 1'b1; push_cfg(cfg_word);
    repeat (4) tick();
    gen_left = 8;
    run_until_drained("lc_timeout", 200);
    repeat (6) tick();
    chk("lc_latches", latch_seen, 2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
